// File: rtl/sram_arb_ctrl_if.sv
// Requester-side bundle of sram_arb_ctrl: two request ports plus shared read data and busy.
// Requesters use the master modport; the controller uses the slave modport.
interface sram_arb_ctrl_if;
  logic        req0;
  logic        req1;
  logic        wr0;
  logic        wr1;
  logic [14:0] addr0;
  logic [14:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic        done0;
  logic        done1;
  logic [7:0]  rdata;
  logic        busy;

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata, busy
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata, busy
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-port arbiter and access sequencer for an asynchronous 32Kx8 SRAM (IDLE/SETUP/STROBE/HOLD).
// Define SRAM_ARB_CTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sram_arb_ctrl #(
  parameter int unsigned WAIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arb_ctrl_if.slave bus,
  output logic [14:0]    sram_a,
  output logic           sram_ce_n,
  output logic           sram_we_n,
  output logic           sram_oe_n,
  output logic [7:0]     sram_dout,
  input  logic [7:0]     sram_din
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        pick;

`ifdef SRAM_ARB_CTRL_RR_EN
  logic last_q, last_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    pick = (bus.req0 && bus.req1) ? ~last_q : ~bus.req0;
  end
`else
  assign pick = ~bus.req0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef SRAM_ARB_CTRL_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d = StSetup;
          gnt_d   = pick;
          wr_d    = pick ? bus.wr1 : bus.wr0;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
`ifdef SRAM_ARB_CTRL_RR_EN
          last_d  = pick;
`endif
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 4'(WAIT - 1);
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          if (!wr_q) rdata_d = sram_din;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from the state register so reset deasserts them without a clock.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    unique case (state_q)
      StSetup: sram_we_n = ~wr_q;
      StStrobe: begin
        sram_ce_n = 1'b0;
        sram_we_n = ~wr_q;
        sram_oe_n = wr_q;
      end
      StHold: begin
        sram_we_n = ~wr_q;
        bus.done0 = ~gnt_q;
        bus.done1 = gnt_q;
      end
      default: ;
    endcase
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.rdata = rdata_q;
  assign sram_a    = addr_q;
  assign sram_dout = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 15'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SRAM_ARB_CTRL_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: directed vector table, corner sequences and randomized batches
// checked against a transaction-level model (arbitration order, latency, memory contents).
module tb_sram_arb_ctrl;
  localparam int unsigned W = 2;
`ifdef SRAM_ARB_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT with a behavioural SRAM.
  sram_arb_ctrl_if bus ();
  logic [14:0] sram_a;
  logic        ce_n, we_n, oe_n;
  logic [7:0]  dout, din;
  logic [7:0]  mem [32768];

  sram_arb_ctrl #(.WAIT(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sram_a(sram_a), .sram_ce_n(ce_n),
    .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_dout(dout), .sram_din(din)
  );

  assign din = mem[sram_a];
  always @(negedge ce_n) if (!we_n) mem[sram_a] <= dout;

  // Extreme WAIT values; their read data is the low address byte.
  sram_arb_ctrl_if bus1 ();
  sram_arb_ctrl_if bus15 ();
  logic [14:0] a1, a15;
  logic        ce1, we1, oe1, ce15, we15, oe15;
  logic [7:0]  dout1, dout15;

  sram_arb_ctrl #(.WAIT(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sram_a(a1), .sram_ce_n(ce1),
    .sram_we_n(we1), .sram_oe_n(oe1), .sram_dout(dout1), .sram_din(a1[7:0])
  );
  sram_arb_ctrl #(.WAIT(15)) u_dut_w15 (
    .clk(clk), .rst_n(rst_n), .bus(bus15), .sram_a(a15), .sram_ce_n(ce15),
    .sram_we_n(we15), .sram_oe_n(oe15), .sram_dout(dout15), .sram_din(a15[7:0])
  );

  typedef struct {
    logic        port;
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t        vt [8];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          win_len = 0;
  logic [14:0] win_a;
  logic [7:0]  win_d;
  logic        win_we;
  int          obs_port [2];
  int          obs_lat [2];
  logic [7:0]  obs_rd [2];
  int          n_obs;
  int          d1_q [$];
  int          d15_q [$];
  logic [7:0]  ref_mem [logic [14:0]];
  logic [7:0]  rd_ref;
  bit          last_ref;
  logic [14:0] pool [8];
  logic        rw [2];
  logic [14:0] ra [2];
  logic [7:0]  rdd [2];
  logic [1:0]  mask;
  bit          first, exp_p, p;
  int          t, n, prev, need;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle step; also watches strobe-window invariants on every DUT.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus1.done0) d1_q.push_back(cyc);
    if (bus15.done0) d15_q.push_back(cyc);
    if (!ce1) chk("w1_oe_we_excl", 32'(!we1 && !oe1), 0);
    if (!ce15) chk("w15_oe_we_excl", 32'(!we15 && !oe15), 0);
    if (!ce_n) chk("oe_we_excl", 32'(!we_n && !oe_n), 0);
    if (bus.done0 || bus.done1) chk("done_exclusive", 32'(bus.done0 && bus.done1), 0);
    if (rst_n && !ce_n) begin
      if (win_len == 0) begin
        win_a = sram_a; win_d = dout; win_we = we_n;
      end else begin
        chk("strobe_stable", 32'({sram_a, dout, we_n}), 32'({win_a, win_d, win_we}));
      end
      win_len++;
    end else begin
      if (rst_n && win_len != 0) chk("strobe_len", win_len, W);
      win_len = 0;
    end
  endtask

  // Raise the requests in mask, drop each as it completes, record completion order/latency/rdata.
  task automatic run_batch(input logic [1:0] m, input logic w0, input logic [14:0] ad0,
                           input logic [7:0] d0, input logic w1, input logic [14:0] ad1,
                           input logic [7:0] d1);
    int tt, nd;
    nd = (m == 2'b11) ? 2 : 1;
    n_obs = 0;
    tt = 0;
    bus.req0 = m[0]; bus.wr0 = w0; bus.addr0 = ad0; bus.wdata0 = d0;
    bus.req1 = m[1]; bus.wr1 = w1; bus.addr1 = ad1; bus.wdata1 = d1;
    while (n_obs < nd && tt < 60) begin
      tick();
      tt++;
      if (bus.done0 || bus.done1) begin
        obs_port[n_obs] = bus.done1 ? 1 : 0;
        obs_lat[n_obs] = tt;
        obs_rd[n_obs] = bus.rdata;
        n_obs++;
        if (bus.done0) bus.req0 = 1'b0;
        if (bus.done1) bus.req1 = 1'b0;
      end
    end
    chk("batch_done_count", n_obs, nd);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 15'h1234, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 1'b1, 15'h7FFF, 8'h3C, 8'hA5};
    vt[3] = '{1'b1, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
    vt[4] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'h3C};
    vt[5] = '{1'b1, 1'b1, 15'h0000, 8'h5A, 8'h3C};
    vt[6] = '{1'b0, 1'b0, 15'h0000, 8'h00, 8'h5A};
    vt[7] = '{1'b1, 1'b0, 15'h1234, 8'h00, 8'hA5};
    pool = '{15'h1234, 15'h7FFF, 15'h0000, 15'h0001, 15'h4000, 15'h2AAA, 15'h5555, 15'h7FFE};

    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus1.req0 = 0; bus1.req1 = 0; bus1.wr0 = 0; bus1.wr1 = 0;
    bus1.addr0 = 15'h0123; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;
    bus15.req0 = 0; bus15.req1 = 0; bus15.wr0 = 0; bus15.wr1 = 0;
    bus15.addr0 = 15'h0045; bus15.addr1 = 0; bus15.wdata0 = 0; bus15.wdata1 = 0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_done0", bus.done0, 0);
    chk("rst_done1", bus.done1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_sram_dout", dout, 0);
    tick();
    tick();
    rst_n = 1'b1;
    last_ref = 1'b1;
    rd_ref = 8'h00;

    // Directed single-port vectors.
    for (int i = 0; i < 8; i++) begin
      if (vt[i].port) run_batch(2'b10, 1'b0, 15'd0, 8'd0, vt[i].wr, vt[i].addr, vt[i].data);
      else run_batch(2'b01, vt[i].wr, vt[i].addr, vt[i].data, 1'b0, 15'd0, 8'd0);
      chk("vec_port", obs_port[0], 32'(vt[i].port));
      chk("vec_latency", obs_lat[0], W + 2);
      chk("vec_rdata", obs_rd[0], 32'(vt[i].exp_rd));
      last_ref = vt[i].port;
    end
    rd_ref = 8'hA5;

    // Both ports reading, requests held continuously.
    bus.wr0 = 1'b0; bus.addr0 = 15'h1234; bus.wr1 = 1'b0; bus.addr1 = 15'h1234;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    exp_p = RR ? !last_ref : 1'b0;
    n = 0; t = 0; prev = 0;
    while (n < 4 && t < 80) begin
      tick();
      t++;
      if (bus.done0 || bus.done1) begin
        chk("contend_port", bus.done1, 32'(exp_p));
        chk("contend_rdata", bus.rdata, 8'hA5);
        if (n > 0) chk("contend_spacing", t - prev, W + 3);
        prev = t;
        n++;
        last_ref = exp_p;
        exp_p = RR ? !exp_p : 1'b0;
        if (n == 4) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
    end
    chk("contend_count", n, 4);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Seed the random address pool so every later read has a known value.
    for (int i = 0; i < 8; i++) begin
      rdd[0] = 8'($urandom);
      run_batch(2'b01, 1'b1, pool[i], rdd[0], 1'b0, 15'd0, 8'd0);
      ref_mem[pool[i]] = rdd[0];
      last_ref = 1'b0;
      chk("seed_latency", obs_lat[0], W + 2);
    end

    // Random batches against the transaction-level model.
    for (int b = 0; b < 40; b++) begin
      mask = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        rw[k] = 1'($urandom);
        ra[k] = pool[$urandom_range(0, 7)];
        rdd[k] = 8'($urandom);
      end
      run_batch(mask, rw[0], ra[0], rdd[0], rw[1], ra[1], rdd[1]);
      need = (mask == 2'b11) ? 2 : 1;
      first = (mask == 2'b11) ? (RR ? !last_ref : 1'b0) : mask[1];
      for (int k = 0; k < need; k++) begin
        p = (k == 0) ? first : !first;
        if (rw[p]) ref_mem[ra[p]] = rdd[p];
        else rd_ref = ref_mem[ra[p]];
        last_ref = p;
        if (k < n_obs) begin
          chk("rand_port", obs_port[k], 32'(p));
          chk("rand_latency", obs_lat[k], (k + 1) * (W + 2) + k);
          chk("rand_rdata", obs_rd[k], 32'(rd_ref));
        end
      end
    end

    // Reset during the strobe of a write, then re-issue.
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 15'h0AAA; bus.wdata0 = 8'h77;
    tick();
    tick();
    chk("abort_in_strobe", ce_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ce_n", ce_n, 1);
    chk("abort_we_n", we_n, 1);
    chk("abort_oe_n", oe_n, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_sram_a", sram_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done0 || bus.done1), 0);
    end
    rst_n = 1'b1;
    last_ref = 1'b1;
    rd_ref = 8'h00;
    t = 0;
    while (!bus.done0 && t < 30) begin
      tick();
      t++;
    end
    chk("reissue_latency", t, W + 2);
    chk("reissue_rdata", bus.rdata, 0);
    bus.req0 = 1'b0;
    last_ref = 1'b0;
    tick();
    run_batch(2'b01, 1'b0, 15'h0AAA, 8'd0, 1'b0, 15'd0, 8'd0);
    rd_ref = 8'h77;
    chk("reissue_readback", obs_rd[0], 32'(rd_ref));

    // Back-to-back reads at WAIT=1 and WAIT=15.
    d1_q.delete();
    d15_q.delete();
    bus1.req0 = 1'b1;
    bus15.req0 = 1'b1;
    for (int i = 0; i < 120 && d15_q.size() < 4; i++) tick();
    chk("w15_done_count", d15_q.size(), 4);
    chk("w1_enough_dones", 32'(d1_q.size() >= 4), 1);
    if (d15_q.size() >= 4)
      for (int i = 1; i < 4; i++) chk("w15_spacing", d15_q[i] - d15_q[i-1], 18);
    if (d1_q.size() >= 4)
      for (int i = 1; i < 4; i++) chk("w1_spacing", d1_q[i] - d1_q[i-1], 4);
    chk("w1_rdata", bus1.rdata, 8'h23);
    chk("w15_rdata", bus15.rdata, 8'h45);
    bus1.req0 = 1'b0;
    bus15.req0 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 SHALL have parameter WAIT, default 2, meaning the number of clk cycles ce_n is held low per access (legal 1..15).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1  access request from port 0 / port 1.
REQ-005 wr0 / wr1  input  1  1 = write, 0 = read, per port.
REQ-006 addr0 / addr1  input  15  word address per port.
REQ-007 wdata0 / wdata1  input  8  write data per port.
REQ-008 done0 / done1  output  1  one-cycle completion pulse per port.
REQ-009 rdata  output  8  read data, shared by both ports.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 sram_a  output  15  address to the 32Kx8 SRAM.
REQ-012 sram_ce_n / sram_we_n / sram_oe_n  output  1  active-low SRAM strobes.
REQ-013 sram_dout  output  8  write data to SRAM data_i; sram_din  input  8  read data from SRAM data_o.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD; HOLD always returns to IDLE, giving one IDLE turnaround cycle between accesses.
REQ-015 In IDLE, when any req is high at a rising edge, SHALL grant one port, latch its wr/addr/wdata, and enter SETUP.
REQ-016 Requester SHALL hold req and its fields stable until its done pulse; controller re-samples req only in IDLE.
REQ-017 SETUP (1 cycle): sram_a = latched address, ce_n=1, oe_n=1, we_n = !wr; sram_dout = latched wdata.
REQ-018 STROBE (exactly WAIT cycles, counted by a 4-bit counter): ce_n=0; write: we_n=0, oe_n=1; read: we_n=1, oe_n=0.
REQ-019 Read: sram_din SHALL be captured into rdata on the rising edge that ends the last STROBE cycle.
REQ-020 HOLD (1 cycle): ce_n=1, oe_n=1; we_n keeps its SETUP value; sram_a and sram_dout unchanged; done of the granted port asserted for this cycle only.
REQ-021 Latency: done asserted WAIT+2 cycles after the grant edge; SRAM write takes effect at the ce_n falling edge.
REQ-022 sram_a, sram_dout and we_n SHALL be stable throughout the window in which ce_n is low.
REQ-023 rdata SHALL hold its value until the next completed read; writes do not alter it.
REQ-024 Outside SETUP/STROBE/HOLD: ce_n=1, we_n=1, oe_n=1; sram_a and sram_dout hold their last values.
REQ-025 done0 and done1 SHALL never be high in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, ce_n=1, we_n=1, oe_n=1, done0=done1=0, busy=0, rdata=0, sram_a=0, sram_dout=0, counter=0.
REQ-027 Reset mid-access SHALL abort the access with no done pulse; the aborted port must re-request.
REQ-028 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-029 Macro SRAM_ARB_CTRL_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; last-granted tracker resets to port 1, so port 0 wins the first tie.
REQ-030 SRAM_ARB_CTRL_RR_EN undefined: fixed priority, port 0 always wins ties; the last-granted tracker is not implemented.
REQ-031 A lone request SHALL be granted in either configuration.

Verification
REQ-032 WAIT=2, req0 write addr 0x1234 data 0xA5, then req0 read 0x1234 -> write done0 4 cycles after grant; read done0 with rdata=0xA5.
REQ-033 req0 and req1 both reads, held high continuously -> RR_EN: grants alternate 0,1,0,1; without RR_EN: port 0 granted every time, port 1 starved.
REQ-034 Write from port 1 to 0x7FFF data 0x3C -> ce_n low for exactly WAIT cycles with we_n=0 and sram_a=0x7FFF throughout; SRAM model reads 0x3C back.
REQ-035 Pull rst_n low during STROBE of a write -> strobes go inactive without waiting for clk, no done pulse, busy=0; re-issued write completes normally.
REQ-036 WAIT=1 and WAIT=15 back-to-back reads -> done spacing of 4 and 18 cycles respectively; oe_n never low while we_n is low.
